frame_assembler: RTL and testbench

Upstream stage of the crc block. Takes 32-bit words from the ingress packet FIFO using a valid/ready handshake and packs them MSB-first into one 768-bit frame. When the frame is complete it presents the frame on data_raw, pulses crc_valid, and waits for crc_done before accepting the next frame. Frames shorter than 24 words are zero-padded; frames longer than 24 words are truncated and flagged.

---
 rtl/frame_assembler.sv | 173 +++++++++++++++++
 tb/tb_frame_assembler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_assembler.sv
// frame_assembler: packs WORD_W-bit words from the ingress FIFO MSB-first into one
// FRAME_W-bit frame, hands the frame to the crc block and waits for crc_done.
// Short packets are zero-padded. Long packets are truncated to WORDS words, flagged
// with trunc_err, and their remaining words are dropped once the crc block is done.
//
// Optional feature macro: FRAME_TIMEOUT_EN
//   defined   - give up waiting for crc_done after TIMEOUT_CYCLES cycles (timeout_err)
//   undefined - wait for crc_done indefinitely; timeout_err tied to 0
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   word handshake with the FIFO; in_data word, in_last end of packet
//   data_raw            assembled frame, held until crc_done
//   crc_valid           one-cycle start pulse to the crc block
//   crc_done            crc block finished with the current frame
//   trunc_err           one-cycle pulse alongside crc_valid when the packet was truncated
//   frame_cnt           frames completed by crc_done (wraps)
//   timeout_err         one-cycle pulse when crc_done never arrived
module frame_assembler #(
    parameter int unsigned WORD_W         = 32,
    parameter int unsigned FRAME_W        = 768,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic [FRAME_W-1:0] data_raw,
    output logic               crc_valid,
    input  logic               crc_done,
    output logic               trunc_err,
    output logic [15:0]        frame_cnt,
    output logic               timeout_err
);

    localparam int unsigned WORDS = FRAME_W / WORD_W;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    if ((FRAME_W % WORD_W) != 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("frame_assembler: FRAME_W must be a multiple of WORD_W, TIMEOUT_CYCLES > 0");
    end

    typedef enum logic [1:0] {StCollect, StSend, StWaitDone, StDiscard} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FRAME_W-1:0] data_raw_q, data_raw_d;
    logic               crc_valid_q, crc_valid_d;
    logic               trunc_q, trunc_d;
    logic               trunc_err_q, trunc_err_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               accept;
`ifdef FRAME_TIMEOUT_EN
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]        timer_q, timer_d;
    logic               timeout_err_q, timeout_err_d;
`endif

    // Gated by rst_n so the FIFO sees no ready while reset is held.
    assign in_ready = rst_n & ((state_q == StCollect) | (state_q == StDiscard));
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        data_raw_d  = data_raw_q;
        trunc_d     = trunc_q;
        frame_cnt_d = frame_cnt_q;
        crc_valid_d = 1'b0;
        trunc_err_d = 1'b0;
`ifdef FRAME_TIMEOUT_EN
        timer_d       = timer_q;
        timeout_err_d = 1'b0;
`endif
        unique case (state_q)
            StCollect: begin
                if (accept) begin
                    for (int w = 0; w < int'(WORDS); w++) begin
                        if (idx_q == IDX_W'(w)) begin
                            data_raw_d[FRAME_W-1-w*WORD_W -: WORD_W] = in_data;
                        end
                    end
                    if (in_last || idx_q == LAST_IDX) begin
                        state_d     = StSend;
                        crc_valid_d = 1'b1;
                        // Frame full but packet continues: the tail gets dropped later.
                        if (!in_last) begin
                            trunc_d     = 1'b1;
                            trunc_err_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StSend: begin
                // crc_done in this cycle is deliberately not looked at.
                state_d = StWaitDone;
`ifdef FRAME_TIMEOUT_EN
                timer_d = '0;
`endif
            end
            StWaitDone: begin
                if (crc_done) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    data_raw_d  = '0;
                    idx_d       = '0;
                    trunc_d     = 1'b0;
                    state_d     = trunc_q ? StDiscard : StCollect;
                end
`ifdef FRAME_TIMEOUT_EN
                else if (timer_q == TIMER_LAST) begin
                    timeout_err_d = 1'b1;
                    data_raw_d    = '0;
                    idx_d         = '0;
                    trunc_d       = 1'b0;
                    state_d       = trunc_q ? StDiscard : StCollect;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
`endif
            end
            StDiscard: begin
                if (accept && in_last) begin
                    state_d = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StCollect;
            idx_q       <= '0;
            data_raw_q  <= '0;
            crc_valid_q <= 1'b0;
            trunc_q     <= 1'b0;
            trunc_err_q <= 1'b0;
            frame_cnt_q <= '0;
`ifdef FRAME_TIMEOUT_EN
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            data_raw_q  <= data_raw_d;
            crc_valid_q <= crc_valid_d;
            trunc_q     <= trunc_d;
            trunc_err_q <= trunc_err_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef FRAME_TIMEOUT_EN
            timer_q       <= timer_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign data_raw  = data_raw_q;
    assign crc_valid = crc_valid_q;
    assign trunc_err = trunc_err_q;
    assign frame_cnt = frame_cnt_q;
`ifdef FRAME_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_assembler.sv
// Self-checking bench for frame_assembler (default build, no timeout feature).
// Expected frames come from a packing model over the list of words in each packet.
module tb_frame_assembler;

    localparam int WW = 32;
    localparam int FW = 768;
    localparam int NW = FW / WW;

    typedef logic [31:0] word_q_t[$];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [WW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [FW-1:0] data_raw;
    logic          crc_valid;
    logic          crc_done = 1'b0;
    logic          trunc_err;
    logic [15:0]   frame_cnt;
    logic          timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    int model_cnt = 0;

    frame_assembler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .data_raw    (data_raw),
        .crc_valid   (crc_valid),
        .crc_done    (crc_done),
        .trunc_err   (trunc_err),
        .frame_cnt   (frame_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Word i of a packet occupies the i-th 32-bit field counted from the MSB end;
    // anything past NW words is not part of the frame.
    function automatic logic [FW-1:0] model_frame(input word_q_t w);
        logic [FW-1:0] f;
        logic [FW-1:0] t;
        f = '0;
        for (int i = 0; i < w.size() && i < NW; i++) begin
            t = FW'(w[i]);
            f = f | (t << (FW - WW * (i + 1)));
        end
        return f;
    endfunction

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push(input logic [31:0] d, input logic last);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $error("FAIL push_timeout: observed no accept required accept of %0h", d);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input word_q_t w, input int done_dly, input bit done_in_send);
        int            n;
        int            nacc;
        logic [FW-1:0] exp;
        n    = w.size();
        nacc = (n > NW) ? NW : n;
        exp  = model_frame(w);
        for (int i = 0; i < nacc; i++) begin
            repeat ($urandom_range(0, 1)) tick();
            push(w[i], (i == n - 1));
        end
        // Cycle right after the last accepted word.
        chk("crc_valid_pulse", FW'(crc_valid), FW'(1'b1));
        chk("trunc_err_flag", FW'(trunc_err), FW'(n > NW));
        chk("frame_data", data_raw, exp);
        chk("ready_low_send", FW'(in_ready), '0);
        if (done_in_send) crc_done = 1'b1;
        tick();
        crc_done = 1'b0;
        chk("crc_valid_one_cycle", FW'(crc_valid), '0);
        chk("trunc_err_one_cycle", FW'(trunc_err), '0);
        // Backpressure: a valid word must not be taken while waiting.
        in_valid = 1'b1;
        in_data  = $urandom;
        repeat (done_dly) tick();
        chk("ready_low_wait", FW'(in_ready), '0);
        chk("frame_held", data_raw, exp);
        chk("cnt_before_done", FW'(frame_cnt), FW'(16'(model_cnt)));
        crc_done = 1'b1;
        tick();
        crc_done = 1'b0;
        in_valid = 1'b0;
        model_cnt++;
        chk("cnt_after_done", FW'(frame_cnt), FW'(16'(model_cnt)));
        chk("frame_cleared", data_raw, '0);
        chk("ready_after_done", FW'(in_ready), FW'(1'b1));
        for (int i = NW; i < n; i++) begin
            push(w[i], (i == n - 1));
            chk("discard_no_valid", FW'(crc_valid), '0);
            chk("discard_frame_zero", data_raw, '0);
        end
    endtask

    initial begin
        word_q_t w;
        int      len;

        // Reset state
        #1;
        chk("rst_ready", FW'(in_ready), '0);
        chk("rst_data", data_raw, '0);
        chk("rst_valid", FW'(crc_valid), '0);
        chk("rst_cnt", FW'(frame_cnt), '0);
        chk("rst_trunc", FW'(trunc_err), '0);
        chk("rst_timeout", FW'(timeout_err), '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", FW'(in_ready), FW'(1'b1));

        // Full 24-word frame
        w = {};
        for (int i = 0; i < NW; i++) w.push_back(32'(i + 1) << 24);
        send_frame(w, 10, 1'b0);

        // Short frame, plus crc_done landing in the crc_valid cycle
        w = {32'hDEADBEEF, 32'hCAFEBABE, 32'h12345678};
        send_frame(w, 3, 1'b1);

        // crc_done while collecting is ignored
        crc_done = 1'b1;
        tick();
        crc_done = 1'b0;
        chk("idle_done_cnt", FW'(frame_cnt), FW'(16'(model_cnt)));
        chk("idle_done_valid", FW'(crc_valid), '0);
        chk("idle_done_ready", FW'(in_ready), FW'(1'b1));

        // Truncation: 26 words, then a single-word frame
        w = {};
        for (int i = 0; i < 26; i++) w.push_back($urandom);
        send_frame(w, 2, 1'b0);
        w = {32'hA5A5A5A5};
        send_frame(w, 0, 1'b0);

        // Reset in the middle of a frame
        for (int i = 0; i < 5; i++) push($urandom, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_cnt = 0;
        chk("midrst_data", data_raw, '0);
        chk("midrst_valid", FW'(crc_valid), '0);
        chk("midrst_ready", FW'(in_ready), '0);
        chk("midrst_cnt", FW'(frame_cnt), '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        w = {};
        for (int i = 0; i < NW; i++) w.push_back($urandom);
        send_frame(w, 1, 1'b0);

        // Random packets, including exactly-full and overlong ones
        for (int k = 0; k < 8; k++) begin
            len = (k == 0) ? NW : (k == 1) ? NW + 1 : int'($urandom_range(1, 30));
            w = {};
            for (int i = 0; i < len; i++) w.push_back($urandom);
            send_frame(w, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
